// File: rtl/text_console_if.sv
// text_console_if: CPU byte stream, attribute load, text RAM port and cursor.
// The slave view belongs to text_console, the master view to CPU and RAM.
interface text_console_if;
    logic [7:0]  data_in;
    logic        data_valid;
    logic        ready;
    logic [7:0]  attr_in;
    logic        attr_we;
    logic [11:0] mem_address;
    logic [7:0]  mem_wdata;
    logic        mem_we;
    logic [7:0]  mem_rdata;
    logic [10:0] cursor;

    modport slave (
        input  data_in, data_valid, attr_in, attr_we, mem_rdata,
        output ready, mem_address, mem_wdata, mem_we, cursor
    );

    modport master (
        output data_in, data_valid, attr_in, attr_we, mem_rdata,
        input  ready, mem_address, mem_wdata, mem_we, cursor
    );
endinterface

// File: rtl/text_console.sv
// text_console: byte stream to 80x25 text RAM writer with cursor tracking.
// Scrolling on the last row is enabled by defining TEXT_CONSOLE_SCROLL_EN.
module text_console #(
    parameter int         COLS     = 80,
    parameter int         ROWS     = 25,
    parameter logic [7:0] DEF_ATTR = 8'h07
) (
    input logic           clock,
    input logic           reset_n,
    text_console_if.slave bus
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WCHAR = 3'd1;
    localparam logic [2:0] WATTR = 3'd2;
    localparam logic [2:0] ADV   = 3'd3;
    localparam logic [2:0] FILL  = 3'd7;
`ifdef TEXT_CONSOLE_SCROLL_EN
    localparam logic [2:0] SCR_RD   = 3'd4;
    localparam logic [2:0] SCR_WAIT = 3'd5;
    localparam logic [2:0] SCR_WR   = 3'd6;

    localparam logic [11:0] LINE_B   = 12'(2 * COLS);
    localparam logic [11:0] SCR_LAST = 12'(2 * COLS * (ROWS - 1) - 1);
    localparam logic [11:0] SCR_END  = 12'(2 * COLS * (ROWS - 1));
`endif
    localparam logic [6:0]  LAST_COL = 7'(COLS - 1);
    localparam logic [4:0]  LAST_ROW = 5'(ROWS - 1);
    localparam logic [11:0] NBYTE    = 12'(2 * COLS * ROWS);

    logic [2:0]  state_q, state_d;
    logic        ready_q, ready_d;
    logic [11:0] addr_q, addr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        we_q, we_d;
    logic [6:0]  col_q, col_d;
    logic [4:0]  row_q, row_d;
    logic [10:0] cur_q, cur_d;
    logic [11:0] ptr_q, ptr_d;
    logic [7:0]  char_q, char_d;
    logic [7:0]  attr_q, attr_d;
    logic        nl;

`ifndef TEXT_CONSOLE_SCROLL_EN
    logic unused_rdata;
    assign unused_rdata = ^bus.mem_rdata;
`endif

    always_comb begin
        state_d = state_q;
        ready_d = ready_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        we_d    = 1'b0;
        col_d   = col_q;
        row_d   = row_q;
        ptr_d   = ptr_q;
        char_d  = char_q;
        attr_d  = bus.attr_we ? bus.attr_in : attr_q;
        nl      = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (bus.data_valid) begin
                    unique case (1'b1)
                        bus.data_in >= 8'h20: begin
                            char_d  = bus.data_in;
                            state_d = WCHAR;
                            ready_d = 1'b0;
                        end
                        bus.data_in == 8'h0D: col_d = '0;
                        bus.data_in == 8'h0A: nl = 1'b1;
                        bus.data_in == 8'h08: begin
                            if (col_q != '0) col_d = col_q - 7'd1;
                        end
                        bus.data_in == 8'h0C: begin
                            // First fill byte goes out on the accept edge
                            row_d   = '0;
                            col_d   = '0;
                            addr_d  = '0;
                            wdata_d = 8'h20;
                            we_d    = 1'b1;
                            ptr_d   = 12'd1;
                            state_d = FILL;
                            ready_d = 1'b0;
                        end
                        default: ;
                    endcase
                end
            end
            WCHAR: begin
                addr_d  = {cur_q, 1'b0};
                wdata_d = char_q;
                we_d    = 1'b1;
                state_d = WATTR;
            end
            WATTR: begin
                addr_d  = {cur_q, 1'b1};
                wdata_d = attr_q;
                we_d    = 1'b1;
                state_d = ADV;
            end
            ADV: begin
                ready_d = 1'b1;
                state_d = IDLE;
                if (col_q == LAST_COL) nl = 1'b1;
                else col_d = col_q + 7'd1;
            end
`ifdef TEXT_CONSOLE_SCROLL_EN
            SCR_RD: begin
                addr_d  = ptr_q + LINE_B;
                state_d = SCR_WAIT;
            end
            SCR_WAIT: state_d = SCR_WR;
            SCR_WR: begin
                addr_d  = ptr_q;
                wdata_d = bus.mem_rdata;
                we_d    = 1'b1;
                if (ptr_q == SCR_LAST) begin
                    ptr_d   = SCR_END;
                    state_d = FILL;
                end else begin
                    ptr_d   = ptr_q + 12'd1;
                    state_d = SCR_RD;
                end
            end
`endif
            FILL: begin
                if (ptr_q == NBYTE) begin
                    ready_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    addr_d  = ptr_q;
                    wdata_d = ptr_q[0] ? attr_q : 8'h20;
                    we_d    = 1'b1;
                    ptr_d   = ptr_q + 12'd1;
                end
            end
            default: state_d = IDLE;
        endcase

        if (nl) begin
            col_d = '0;
            if (row_q != LAST_ROW) begin
                row_d = row_q + 5'd1;
            end else begin
`ifdef TEXT_CONSOLE_SCROLL_EN
                // Entry edge already issues the first source read
                addr_d  = LINE_B;
                ptr_d   = '0;
                state_d = SCR_WAIT;
                ready_d = 1'b0;
`else
                row_d = '0;
`endif
            end
        end

        cur_d = 11'(row_d) * 11'(COLS) + 11'(col_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            ready_q <= 1'b1;
            addr_q  <= '0;
            wdata_q <= '0;
            we_q    <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            cur_q   <= '0;
            ptr_q   <= '0;
            char_q  <= '0;
            attr_q  <= DEF_ATTR;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            we_q    <= we_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cur_q   <= cur_d;
            ptr_q   <= ptr_d;
            char_q  <= char_d;
            attr_q  <= attr_d;
        end
    end

    assign bus.ready       = ready_q;
    assign bus.mem_address = addr_q;
    assign bus.mem_wdata   = wdata_q;
    assign bus.mem_we      = we_q;
    assign bus.cursor      = cur_q;

endmodule

// File: tb/tb_text_console.sv
// tb_text_console: directed vectors plus hand sequences for text_console.
// Covers default build and TEXT_CONSOLE_SCROLL_EN scroll behaviour.
module tb_text_console;

    localparam int LIMIT = 20000;

    logic clock;
    logic reset_n;
    logic pat_req;

    text_console_if bus ();

    text_console dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] mem [0:4095];
    logic [7:0] rdata_q;
    int         wcnt = 0;

    always @(posedge clock) begin
        if (pat_req) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 8'(i);
        end else if (bus.mem_we) begin
            mem[bus.mem_address] <= bus.mem_wdata;
            wcnt <= wcnt + 1;
        end
        rdata_q <= mem[bus.mem_address];
    end

    assign bus.mem_rdata = rdata_q;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h (%0d) expected 0x%0h (%0d)",
                     name, act, act, exp, exp);
        end
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!bus.ready && n < LIMIT) begin
            @(posedge clock);
            #1;
            n++;
        end
    endtask

    task automatic send(input logic [7:0] d, input logic aw,
                        input logic [7:0] a, output int busy, output int wr);
        int w0;
        int n;
        wait_ready(n);
        bus.data_in    = d;
        bus.data_valid = 1'b1;
        bus.attr_we    = aw;
        bus.attr_in    = a;
        w0 = wcnt;
        @(posedge clock);
        #1;
        bus.data_valid = 1'b0;
        bus.attr_we    = 1'b0;
        wait_ready(busy);
        wr = wcnt - w0;
    endtask

    task automatic set_attr(input logic [7:0] a);
        bus.attr_in = a;
        bus.attr_we = 1'b1;
        @(posedge clock);
        #1;
        bus.attr_we = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  data;
        logic        aw;
        logic [7:0]  attr;
        logic [10:0] cur;
        int          busy;
        int          wr;
    } vec_t;

    vec_t vecs [18];

    initial begin
        int b;
        int w;
        int n;

        vecs[0]  = '{8'h42, 1'b0, 8'h00, 11'd2,   3,    2};
        vecs[1]  = '{8'h0D, 1'b0, 8'h00, 11'd0,   0,    0};
        vecs[2]  = '{8'h0A, 1'b0, 8'h00, 11'd80,  0,    0};
        vecs[3]  = '{8'h01, 1'b0, 8'h00, 11'd80,  0,    0};
        vecs[4]  = '{8'h08, 1'b0, 8'h00, 11'd80,  0,    0};
        vecs[5]  = '{8'h78, 1'b1, 8'h31, 11'd81,  3,    2};
        vecs[6]  = '{8'h0D, 1'b0, 8'h00, 11'd80,  0,    0};
        vecs[7]  = '{8'h61, 1'b0, 8'h00, 11'd81,  3,    2};
        vecs[8]  = '{8'h62, 1'b0, 8'h00, 11'd82,  3,    2};
        vecs[9]  = '{8'h63, 1'b0, 8'h00, 11'd83,  3,    2};
        vecs[10] = '{8'h64, 1'b0, 8'h00, 11'd84,  3,    2};
        vecs[11] = '{8'h65, 1'b0, 8'h00, 11'd85,  3,    2};
        vecs[12] = '{8'h08, 1'b0, 8'h00, 11'd84,  0,    0};
        vecs[13] = '{8'h08, 1'b0, 8'h00, 11'd83,  0,    0};
        vecs[14] = '{8'h0D, 1'b0, 8'h00, 11'd80,  0,    0};
        vecs[15] = '{8'hFF, 1'b0, 8'h00, 11'd81,  3,    2};
        vecs[16] = '{8'h1F, 1'b0, 8'h00, 11'd81,  0,    0};
        vecs[17] = '{8'h0C, 1'b0, 8'h00, 11'd0,   4000, 4000};

        reset_n        = 1'b0;
        pat_req        = 1'b0;
        bus.data_in    = '0;
        bus.data_valid = 1'b0;
        bus.attr_in    = '0;
        bus.attr_we    = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst ready", int'(bus.ready), 1);
        chk("rst cursor", int'(bus.cursor), 0);
        chk("rst mem_we", int'(bus.mem_we), 0);
        chk("rst addr", int'(bus.mem_address), 0);
        chk("rst wdata", int'(bus.mem_wdata), 0);
        reset_n = 1'b1;
        @(posedge clock);
        #1;

        // 'A' with coincident attribute load, cycle by cycle
        bus.data_in    = 8'h41;
        bus.data_valid = 1'b1;
        bus.attr_in    = 8'h1E;
        bus.attr_we    = 1'b1;
        @(posedge clock);
        #1;
        bus.data_valid = 1'b0;
        bus.attr_we    = 1'b0;
        chk("A ready e0", int'(bus.ready), 0);
        chk("A we e0", int'(bus.mem_we), 0);
        @(posedge clock);
        #1;
        chk("A we e1", int'(bus.mem_we), 1);
        chk("A addr e1", int'(bus.mem_address), 0);
        chk("A wdata e1", int'(bus.mem_wdata), 'h41);
        @(posedge clock);
        #1;
        chk("A we e2", int'(bus.mem_we), 1);
        chk("A addr e2", int'(bus.mem_address), 1);
        chk("A wdata e2", int'(bus.mem_wdata), 'h1E);
        chk("A ready e2", int'(bus.ready), 0);
        @(posedge clock);
        #1;
        chk("A ready e3", int'(bus.ready), 1);
        chk("A cursor", int'(bus.cursor), 1);
        chk("A we e3", int'(bus.mem_we), 0);
        chk("A mem0", int'(mem[0]), 'h41);
        chk("A mem1", int'(mem[1]), 'h1E);

        for (int i = 0; i < 18; i++) begin
            send(vecs[i].data, vecs[i].aw, vecs[i].attr, b, w);
            chk($sformatf("vec%0d cursor", i), int'(bus.cursor), int'(vecs[i].cur));
            chk($sformatf("vec%0d busy", i), b, vecs[i].busy);
            chk($sformatf("vec%0d writes", i), w, vecs[i].wr);
        end
        chk("ff mem0", int'(mem[0]), 'h20);
        chk("ff mem160", int'(mem[160]), 'h20);
        chk("ff mem161", int'(mem[161]), 'h31);
        chk("ff mem3999", int'(mem[3999]), 'h31);

        for (int i = 0; i < 80; i++) send(8'h30 + 8'(i % 10), 1'b0, 8'h00, b, w);
        chk("row cursor", int'(bus.cursor), 80);
        chk("row mem0", int'(mem[0]), 'h30);
        chk("row mem158", int'(mem[158]), 'h39);
        chk("row mem159", int'(mem[159]), 'h31);

        for (int i = 0; i < 23; i++) send(8'h0A, 1'b0, 8'h00, b, w);
        chk("lf cursor", int'(bus.cursor), 1920);

        pat_req = 1'b1;
        @(posedge clock);
        #1;
        pat_req = 1'b0;
        set_attr(8'h2A);
        send(8'h0A, 1'b0, 8'h00, b, w);
`ifdef TEXT_CONSOLE_SCROLL_EN
        chk("scr busy", b, 11680);
        chk("scr cursor", int'(bus.cursor), 1920);
        chk("scr writes", w, 4000);
        chk("scr mem0", int'(mem[0]), 'hA0);
        chk("scr mem1", int'(mem[1]), 'hA1);
        chk("scr mem3839", int'(mem[3839]), 'h9F);
        chk("scr mem3840", int'(mem[3840]), 'h20);
        chk("scr mem3841", int'(mem[3841]), 'h2A);
        chk("scr mem3999", int'(mem[3999]), 'h2A);
        chk("scr mem4000", int'(mem[4000]), 'hA0);
`else
        chk("wrap busy", b, 0);
        chk("wrap cursor", int'(bus.cursor), 0);
        chk("wrap writes", w, 0);
        chk("wrap mem5", int'(mem[5]), 'h05);
        chk("wrap mem3845", int'(mem[3845]), 'h05);
`endif

        // Attribute change in the middle of a clear
        wait_ready(n);
        bus.data_in    = 8'h0C;
        bus.data_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.data_valid = 1'b0;
        repeat (9) @(posedge clock);
        #1;
        set_attr(8'h55);
        wait_ready(n);
        chk("mid busy", n + 10, 4000);
        chk("mid cursor", int'(bus.cursor), 0);
        chk("mid mem1", int'(mem[1]), 'h2A);
        chk("mid mem9", int'(mem[9]), 'h2A);
        chk("mid mem11", int'(mem[11]), 'h55);
        chk("mid mem3999", int'(mem[3999]), 'h55);

        // Reset aborts a clear in progress
        bus.data_in    = 8'h0C;
        bus.data_valid = 1'b1;
        @(posedge clock);
        #1;
        bus.data_valid = 1'b0;
        repeat (100) @(posedge clock);
        #1;
        chk("pre-rst busy", int'(bus.ready), 0);
        reset_n = 1'b0;
        #1;
        chk("arst ready", int'(bus.ready), 1);
        chk("arst cursor", int'(bus.cursor), 0);
        chk("arst we", int'(bus.mem_we), 0);
        chk("arst addr", int'(bus.mem_address), 0);
        chk("arst wdata", int'(bus.mem_wdata), 0);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        @(posedge clock);
        #1;
        chk("post-rst ready", int'(bus.ready), 1);
        chk("post-rst we", int'(bus.mem_we), 0);
        send(8'h5A, 1'b0, 8'h00, b, w);
        chk("Z busy", b, 3);
        chk("Z cursor", int'(bus.cursor), 1);
        chk("Z mem0", int'(mem[0]), 'h5A);
        chk("Z mem1 def attr", int'(mem[1]), 'h07);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
